// File: rtl/mcsr_v2.sv
// Machine-level CSR file: trap CSRs, 64-bit counters, local interrupt lines,
// fixed-priority interrupt arbitration and vectored mtvec.
module mcsr_v2 #(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned NUM_LOCAL_IRQ = 4,
  parameter int unsigned CNT_WIDTH     = 64,
  parameter logic [31:0] VECTOR_ENTRY  = 32'h0000_0000,
  parameter logic [31:0] HART_ID       = 32'h0000_0000
) (
  input  logic                                          cpu_clk,
  input  logic                                          cpu_rst,
  input  logic [11:0]                                   csr_addr,
  input  logic                                          csr_rd,
  input  logic                                          csr_wr,
  input  logic [1:0]                                    csr_op,
  input  logic [XLEN-1:0]                               csr_wdata,
  output logic [XLEN-1:0]                               csr_rdata,
  output logic                                          csr_illegal,
  input  logic                                          meip,
  input  logic                                          mtip,
  input  logic                                          msip,
  input  logic [(NUM_LOCAL_IRQ > 0 ? NUM_LOCAL_IRQ : 1)-1:0] lirq,
  input  logic                                          instr_retire,
  input  logic                                          trap_valid,
  input  logic [3:0]                                    trap_cause,
  input  logic [31:0]                                   trap_epc,
  input  logic [31:0]                                   trap_tval,
  input  logic                                          mret,
  output logic                                          irq_req,
  output logic [4:0]                                    irq_cause,
  input  logic                                          irq_ack,
  output logic [31:0]                                   trap_pc,
  output logic [31:0]                                   mepc_out,
  output logic                                          mstatus_mie
);

  localparam int unsigned HW       = CNT_WIDTH - 32;
  localparam logic [31:0] MIE_MASK = 32'h0000_0888 | (((32'h1 << NUM_LOCAL_IRQ) - 32'h1) << 16);

  localparam logic [11:0] A_MSTATUS = 12'h300, A_MISA    = 12'h301, A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC   = 12'h305, A_MCNTINH = 12'h320, A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC    = 12'h341, A_MCAUSE  = 12'h342, A_MTVAL    = 12'h343;
  localparam logic [11:0] A_MIP     = 12'h344, A_MCYCLE  = 12'hB00, A_MINSTRET = 12'hB02;
  localparam logic [11:0] A_MCYCLEH = 12'hB80, A_MINSTRH = 12'hB82, A_MVENDOR  = 12'hF11;
  localparam logic [11:0] A_MARCH   = 12'hF12, A_MIMP    = 12'hF13, A_MHART    = 12'hF14;

  logic                 r_mstatus_mie, r_mstatus_mpie;
  logic [31:0]          r_mie_en, r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval;
  logic [2:0]           r_cntinh;
  logic [CNT_WIDTH-1:0] r_mcycle, r_minstret;
  logic                 r_irq_req;
  logic [4:0]           r_irq_cause;

  logic [31:0] w_mip, w_pend, w_rdval, w_wval, w_base;
  logic        w_hit, w_illegal, w_we, w_lfound, w_trap_blk;
  logic [4:0]  w_cause;

  always_comb begin
    w_mip     = '0;
    w_mip[3]  = msip;
    w_mip[7]  = mtip;
    w_mip[11] = meip;
    for (int unsigned i = 0; i < NUM_LOCAL_IRQ; i++) w_mip[16+i] = lirq[i];
  end

  always_comb begin
    w_hit   = 1'b1;
    w_rdval = '0;
    case (csr_addr)
      A_MSTATUS:  w_rdval = {24'b0, r_mstatus_mpie, 3'b0, r_mstatus_mie, 3'b0};
      A_MISA:     w_rdval = 32'h4000_1100;
      A_MIE:      w_rdval = r_mie_en;
      A_MTVEC:    w_rdval = r_mtvec;
      A_MCNTINH:  w_rdval = {29'b0, r_cntinh};
      A_MSCRATCH: w_rdval = r_mscratch;
      A_MEPC:     w_rdval = r_mepc;
      A_MCAUSE:   w_rdval = r_mcause;
      A_MTVAL:    w_rdval = r_mtval;
      A_MIP:      w_rdval = w_mip;
      A_MCYCLE:   w_rdval = r_mcycle[31:0];
      A_MINSTRET: w_rdval = r_minstret[31:0];
      A_MCYCLEH:  w_rdval = 32'(r_mcycle >> 32);
      A_MINSTRH:  w_rdval = 32'(r_minstret >> 32);
      A_MVENDOR:  w_rdval = '0;
      A_MARCH:    w_rdval = '0;
      A_MIMP:     w_rdval = 32'h2000_0000;
      A_MHART:    w_rdval = HART_ID;
      default:    w_hit   = 1'b0;
    endcase
  end

  assign w_illegal   = (csr_rd | csr_wr) & (~w_hit | (csr_wr & (csr_addr[11:10] == 2'b11)));
  assign csr_illegal = w_illegal;
  assign csr_rdata   = (csr_rd & ~w_illegal) ? w_rdval : '0;
  assign w_we        = csr_wr & ~w_illegal;

  // Old value comes from the read mux, so non-writable bits already read as 0.
  always_comb begin
    case (csr_op)
      2'b01:   w_wval = w_rdval | csr_wdata;
      2'b10:   w_wval = w_rdval & ~csr_wdata;
      default: w_wval = csr_wdata;
    endcase
  end

  // Later assignments override earlier ones: MEI > MSI > MTI > lirq[0] > ...
  assign w_pend = w_mip & r_mie_en;
  always_comb begin
    w_cause  = '0;
    w_lfound = 1'b0;
    for (int unsigned i = 0; i < NUM_LOCAL_IRQ; i++) begin
      if (w_pend[16+i] && !w_lfound) begin
        w_cause  = 5'(16 + i);
        w_lfound = 1'b1;
      end
    end
    if (w_pend[7])  w_cause = 5'd7;
    if (w_pend[3])  w_cause = 5'd3;
    if (w_pend[11]) w_cause = 5'd11;
  end

  assign w_base  = {r_mtvec[31:2], 2'b00};
  assign trap_pc = (r_mtvec[1:0] == 2'b01 && irq_ack) ? w_base + {25'b0, r_irq_cause, 2'b00} : w_base;

  assign w_trap_blk = trap_valid | irq_ack | mret;

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mepc         <= '0;
      r_mcause       <= '0;
      r_mtval        <= '0;
      r_mie_en       <= '0;
      r_mtvec        <= {VECTOR_ENTRY[31:2], 2'b00};
      r_mscratch     <= '0;
      r_cntinh       <= '0;
      r_irq_req      <= 1'b0;
      r_irq_cause    <= '0;
    end else begin
      if (trap_valid) begin
        r_mepc         <= trap_epc & ~32'h3;
        r_mcause       <= {28'b0, trap_cause};
        r_mtval        <= trap_tval;
        r_mstatus_mpie <= r_mstatus_mie;
        r_mstatus_mie  <= 1'b0;
      end else if (irq_ack) begin
        r_mepc         <= trap_epc & ~32'h3;
        r_mcause       <= {1'b1, 26'b0, r_irq_cause};
        r_mtval        <= '0;
        r_mstatus_mpie <= r_mstatus_mie;
        r_mstatus_mie  <= 1'b0;
      end else if (mret) begin
        r_mstatus_mie  <= r_mstatus_mpie;
        r_mstatus_mpie <= 1'b1;
      end else if (w_we && csr_addr == A_MSTATUS) begin
        r_mstatus_mie  <= w_wval[3];
        r_mstatus_mpie <= w_wval[7];
      end
      if (w_we && !w_trap_blk && csr_addr == A_MEPC)   r_mepc   <= w_wval & ~32'h3;
      if (w_we && !w_trap_blk && csr_addr == A_MCAUSE) r_mcause <= w_wval;
      if (w_we && !w_trap_blk && csr_addr == A_MTVAL)  r_mtval  <= w_wval;
      if (w_we && csr_addr == A_MIE)      r_mie_en   <= w_wval & MIE_MASK;
      if (w_we && csr_addr == A_MTVEC)    r_mtvec    <= {w_wval[31:2], w_wval[1] ? 2'b00 : w_wval[1:0]};
      if (w_we && csr_addr == A_MSCRATCH) r_mscratch <= w_wval;
      if (w_we && csr_addr == A_MCNTINH)  r_cntinh   <= {w_wval[2], 1'b0, w_wval[0]};
      r_irq_req   <= !irq_ack && !trap_valid && r_mstatus_mie && (|w_pend);
      r_irq_cause <= w_cause;
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      r_mcycle   <= '0;
      r_minstret <= '0;
    end else begin
      if (w_we && csr_addr == A_MCYCLE)       r_mcycle <= {r_mcycle[CNT_WIDTH-1:32], w_wval};
      else if (w_we && csr_addr == A_MCYCLEH) r_mcycle <= {w_wval[HW-1:0], r_mcycle[31:0]};
      else if (!r_cntinh[0])                  r_mcycle <= r_mcycle + 1'b1;
      if (w_we && csr_addr == A_MINSTRET)     r_minstret <= {r_minstret[CNT_WIDTH-1:32], w_wval};
      else if (w_we && csr_addr == A_MINSTRH) r_minstret <= {w_wval[HW-1:0], r_minstret[31:0]};
      else if (instr_retire && !r_cntinh[2])  r_minstret <= r_minstret + 1'b1;
    end
  end

  assign irq_req     = r_irq_req;
  assign irq_cause   = r_irq_cause;
  assign mepc_out    = r_mepc;
  assign mstatus_mie = r_mstatus_mie;

endmodule
